l2_ahb_in_stg: RTL and testbench

//  Bus-matrix input stage: one per master port, directly upstream of the output stage.

---
 rtl/l2_ahb_in_stg.sv | 162 ++++++++++++++++
 tb/tb_l2_ahb_in_stg.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_ahb_in_stg.sv
// l2_ahb_in_stg
// Bus-matrix input stage, one instance per master port. Each valid AHB
// address phase from the master is registered and offered to the output
// stage as a held transfer until arbitration selects this port. While the
// transfer waits, the master is stalled. Once it is granted, the slave
// response is returned through the output stage's HREADYMUXM.
//
// Handshake: a transfer is accepted when HSELS & HREADYS & HTRANSS[1]. It is
// offered downstream (held_tran_op=1) until active_op & HREADYMUXM. The data
// phase then completes on the first cycle in which HREADYMUXM=1.
//
// Ports
//   HCLK, HRESET           clock, synchronous active-high reset
//   HSELS..HMASTLOCKS      master address/control phase
//   HWDATAS                master write data
//   HREADYS                master-bus HREADY
//   HREADYOUTS/HRESPS/HRDATAS  response to the master
//   sel_op..master_op      held address/control to the output stage
//   mastlock_op            registered lock, valid in every state
//   wdata_op               write data, passed straight through
//   held_tran_op           transfer pending arbitration
//   active_op              output stage has selected this port
//   HREADYMUXM/HRESPM/HRDATAM  slave response via the output stage
//   dbg_state_op           FSM state (0 IDLE, 1 PEND, 2 DATA)
module l2_ahb_in_stg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MID_W  = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic [MID_W-1:0]  HMASTERS,
  input  logic              HMASTLOCKS,
  input  logic [DATA_W-1:0] HWDATAS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic [DATA_W-1:0] HRDATAS,
  output logic              sel_op,
  output logic [ADDR_W-1:0] addr_op,
  output logic [1:0]        trans_op,
  output logic              write_op,
  output logic [2:0]        size_op,
  output logic [2:0]        burst_op,
  output logic [3:0]        prot_op,
  output logic [MID_W-1:0]  master_op,
  output logic              mastlock_op,
  output logic [DATA_W-1:0] wdata_op,
  output logic              held_tran_op,
  input  logic              active_op,
  input  logic              HREADYMUXM,
  input  logic              HRESPM,
  input  logic [DATA_W-1:0] HRDATAM,
  output logic [1:0]        dbg_state_op
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [2:0]          r_size;
  logic [3:0]          r_prot;
  logic [MID_W-1:0]    r_master;
  logic                r_mastlock;

  logic w_acc;
  logic w_pend;
  logic w_data;
  logic w_load;
  logic w_unused;

  assign w_acc  = HSELS & HREADYS & HTRANSS[1];
  assign w_pend = (r_state == ST_PEND);
  assign w_data = (r_state == ST_DATA);

  // A new address phase is captured from IDLE, or from DATA on the cycle the
  // current data phase completes (back-to-back, no IDLE bubble).
  assign w_load = w_acc & ((r_state == ST_IDLE) | (w_data & HREADYMUXM));

  // The burst type and SEQ/NONSEQ distinction are not forwarded: every beat
  // is re-issued as a SINGLE NONSEQ because of the gaps between beats.
  assign w_unused = ^{HBURSTS, HTRANSS[0]};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_size     <= '0;
      r_prot     <= '0;
      r_master   <= '0;
      r_mastlock <= 1'b0;
    end else begin
      // Lock follows the master bus on every completed cycle, independent of
      // the FSM, so a locked sequence survives gaps between beats.
      if (HREADYS) begin
        r_mastlock <= HMASTLOCKS;
      end

      if (w_load) begin
        r_addr   <= HADDRS;
        r_write  <= HWRITES;
        r_size   <= HSIZES;
        r_prot   <= HPROTS;
        r_master <= HMASTERS;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_state <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (active_op & HREADYMUXM) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (HREADYMUXM) begin
            r_state <= w_acc ? ST_PEND : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Master-side response: zero-wait OKAY in IDLE, stall in PEND, slave
  // response passed through in DATA (including the two-cycle ERROR).
  assign HREADYOUTS = w_data ? HREADYMUXM : ~w_pend;
  assign HRESPS     = w_data & HRESPM;
  assign HRDATAS    = w_data ? HRDATAM : '0;

  // Output-stage side: fields are only driven while the transfer is held.
  assign held_tran_op = w_pend;
  assign sel_op       = w_pend;
  assign trans_op     = w_pend ? 2'b10 : 2'b00;
  assign burst_op     = 3'b000;
  assign addr_op      = w_pend ? r_addr   : '0;
  assign write_op     = w_pend & r_write;
  assign size_op      = w_pend ? r_size   : '0;
  assign prot_op      = w_pend ? r_prot   : '0;
  assign master_op    = w_pend ? r_master : '0;

  assign mastlock_op  = r_mastlock;
  assign wdata_op     = HWDATAS;
  assign dbg_state_op = r_state;

endmodule

// File: tb/tb_l2_ahb_in_stg.sv
// Directed, table-driven bench for l2_ahb_in_stg. Each table row is one
// clock cycle: inputs applied after the rising edge, outputs checked on the
// falling edge against hand-computed values.
module tb_l2_ahb_in_stg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MID_W  = 4;

  localparam logic [2:0]       C_SIZE = 3'b010;
  localparam logic [3:0]       C_PROT = 4'h3;
  localparam logic [MID_W-1:0] C_MID  = 4'hA;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic [MID_W-1:0]  hmaster;
  logic              hlock;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;
  logic              sel_op;
  logic [ADDR_W-1:0] addr_op;
  logic [1:0]        trans_op;
  logic              write_op;
  logic [2:0]        size_op;
  logic [2:0]        burst_op;
  logic [3:0]        prot_op;
  logic [MID_W-1:0]  master_op;
  logic              mastlock_op;
  logic [DATA_W-1:0] wdata_op;
  logic              held_tran_op;
  logic              active;
  logic              hreadymuxm;
  logic              hrespm;
  logic [DATA_W-1:0] hrdatam;
  logic [1:0]        dbg_state;

  l2_ahb_in_stg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MID_W(MID_W)) dut (
    .HCLK(clk), .HRESET(rst),
    .HSELS(hsel), .HADDRS(haddr), .HTRANSS(htrans), .HWRITES(hwrite),
    .HSIZES(hsize), .HBURSTS(hburst), .HPROTS(hprot), .HMASTERS(hmaster),
    .HMASTLOCKS(hlock), .HWDATAS(hwdata), .HREADYS(hready),
    .HREADYOUTS(hreadyout), .HRESPS(hresp), .HRDATAS(hrdata),
    .sel_op(sel_op), .addr_op(addr_op), .trans_op(trans_op),
    .write_op(write_op), .size_op(size_op), .burst_op(burst_op),
    .prot_op(prot_op), .master_op(master_op), .mastlock_op(mastlock_op),
    .wdata_op(wdata_op), .held_tran_op(held_tran_op), .active_op(active),
    .HREADYMUXM(hreadymuxm), .HRESPM(hrespm), .HRDATAM(hrdatam),
    .dbg_state_op(dbg_state)
  );

  typedef struct {
    logic        rst;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hrdy;
    logic        hwr;
    logic [31:0] haddr;
    logic [2:0]  hburst;
    logic        hlock;
    logic [31:0] hwdata;
    logic        act;
    logic        mux;
    logic        hrespm;
    logic [31:0] hrdatam;
    logic        e_rdy;
    logic        e_resp;
    logic        e_held;
    logic [31:0] e_addr;
    logic        e_wr;
    logic [31:0] e_rdata;
    logic        e_lock;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int row, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act_v, exp_v);
    end
  endtask

  task automatic add(input logic rst_i, input logic hsel_i, input logic [1:0] htrans_i,
                     input logic hrdy_i, input logic hwr_i, input logic [31:0] haddr_i,
                     input logic [2:0] hburst_i, input logic hlock_i, input logic [31:0] hwdata_i,
                     input logic act_i, input logic mux_i, input logic hrespm_i,
                     input logic [31:0] hrdatam_i,
                     input logic e_rdy_i, input logic e_resp_i, input logic e_held_i,
                     input logic [31:0] e_addr_i, input logic e_wr_i, input logic [31:0] e_rdata_i,
                     input logic e_lock_i, input logic [1:0] e_st_i);
    vec_t v;
    v.rst = rst_i; v.hsel = hsel_i; v.htrans = htrans_i; v.hrdy = hrdy_i;
    v.hwr = hwr_i; v.haddr = haddr_i; v.hburst = hburst_i; v.hlock = hlock_i;
    v.hwdata = hwdata_i; v.act = act_i; v.mux = mux_i; v.hrespm = hrespm_i;
    v.hrdatam = hrdatam_i;
    v.e_rdy = e_rdy_i; v.e_resp = e_resp_i; v.e_held = e_held_i; v.e_addr = e_addr_i;
    v.e_wr = e_wr_i; v.e_rdata = e_rdata_i; v.e_lock = e_lock_i; v.e_st = e_st_i;
    vecs.push_back(v);
  endtask

  // driver: apply one row of inputs
  task automatic drive(input vec_t v);
    rst = v.rst; hsel = v.hsel; htrans = v.htrans; hready = v.hrdy;
    hwrite = v.hwr; haddr = v.haddr; hburst = v.hburst; hlock = v.hlock;
    hwdata = v.hwdata; active = v.act; hreadymuxm = v.mux; hrespm = v.hrespm;
    hrdatam = v.hrdatam;
  endtask

  task automatic check_row(input int row, input vec_t v);
    chk("hreadyouts", row, 64'(hreadyout), 64'(v.e_rdy));
    chk("hresps",     row, 64'(hresp),     64'(v.e_resp));
    chk("held_tran",  row, 64'(held_tran_op), 64'(v.e_held));
    chk("sel_op",     row, 64'(sel_op),    64'(v.e_held));
    chk("trans_op",   row, 64'(trans_op),  v.e_held ? 64'd2 : 64'd0);
    chk("burst_op",   row, 64'(burst_op),  64'd0);
    chk("addr_op",    row, 64'(addr_op),   64'(v.e_addr));
    chk("write_op",   row, 64'(write_op),  64'(v.e_wr));
    chk("size_op",    row, 64'(size_op),   v.e_held ? 64'(C_SIZE) : 64'd0);
    chk("prot_op",    row, 64'(prot_op),   v.e_held ? 64'(C_PROT) : 64'd0);
    chk("master_op",  row, 64'(master_op), v.e_held ? 64'(C_MID)  : 64'd0);
    chk("hrdatas",    row, 64'(hrdata),    64'(v.e_rdata));
    chk("mastlock",   row, 64'(mastlock_op), 64'(v.e_lock));
    chk("wdata_op",   row, 64'(wdata_op),  64'(v.hwdata));
    chk("state",      row, 64'(dbg_state), 64'(v.e_st));
  endtask

  initial begin
    // Stimulus table. Columns:
    // rst hsel htrans rdy wr addr burst lock wdata | act mux respm rdatam
    //   || e_rdy e_resp e_held e_addr e_wr e_rdata e_lock e_state
    // Single NONSEQ write, zero-wait slave
    add(0,1,2'b10,1,1,32'h2000_0040,3'b000,0,32'h0,        1,1,0,32'h0,        1,0,0,32'h0,0,32'h0,0,2'd0);
    add(0,1,2'b10,0,1,32'h2000_0040,3'b000,0,32'hCAFE_F00D,1,1,0,32'h0,        0,0,1,32'h2000_0040,1,32'h0,0,2'd1);
    add(0,0,2'b00,1,0,32'h0,        3'b000,0,32'hCAFE_F00D,0,1,0,32'h5A5A_5A5A,1,0,0,32'h0,0,32'h5A5A_5A5A,0,2'd2);
    // active_op outside PEND ignored; HRDATAS zero outside DATA
    add(0,0,2'b00,1,0,32'h0,        3'b000,0,32'h1,        1,1,0,32'h1234_5678,1,0,0,32'h0,0,32'h0,0,2'd0);
    // unselected NONSEQ, selected BUSY, HREADYS low: none are held
    add(0,0,2'b10,1,0,32'h0000_0800,3'b000,0,32'h2,        0,1,0,32'h0,        1,0,0,32'h0,0,32'h0,0,2'd0);
    add(0,1,2'b01,1,0,32'h0000_0804,3'b000,0,32'h3,        0,1,0,32'h0,        1,0,0,32'h0,0,32'h0,0,2'd0);
    add(0,1,2'b10,0,0,32'h0000_0808,3'b000,0,32'h4,        0,1,0,32'h0,        1,0,0,32'h0,0,32'h0,0,2'd0);
    // INCR4 read at 0x100, grant delayed 3 cycles on beat 1
    add(0,1,2'b10,1,0,32'h0000_0100,3'b011,0,32'h0,        0,1,0,32'h0,        1,0,0,32'h0,0,32'h0,0,2'd0);
    add(0,1,2'b10,0,0,32'h0000_0100,3'b011,0,32'h0,        0,1,0,32'h0,        0,0,1,32'h0000_0100,0,32'h0,0,2'd1);
    add(0,1,2'b10,0,0,32'h0000_0100,3'b011,0,32'h0,        0,1,0,32'h0,        0,0,1,32'h0000_0100,0,32'h0,0,2'd1);
    add(0,1,2'b10,0,0,32'h0000_0100,3'b011,0,32'h0,        0,1,0,32'h0,        0,0,1,32'h0000_0100,0,32'h0,0,2'd1);
    add(0,1,2'b10,0,0,32'h0000_0100,3'b011,0,32'h0,        1,1,0,32'h0,        0,0,1,32'h0000_0100,0,32'h0,0,2'd1);
    // beat 1 completes while beat 2 (SEQ) is accepted: straight to PEND
    add(0,1,2'b11,1,0,32'h0000_0104,3'b011,0,32'h0,        0,1,0,32'h1111_1111,1,0,0,32'h0,0,32'h1111_1111,0,2'd2);
    add(0,1,2'b11,0,0,32'h0000_0104,3'b011,0,32'h0,        1,1,0,32'h0,        0,0,1,32'h0000_0104,0,32'h0,0,2'd1);
    add(0,1,2'b11,1,0,32'h0000_0108,3'b011,0,32'h0,        0,1,0,32'h2222_2222,1,0,0,32'h0,0,32'h2222_2222,0,2'd2);
    add(0,1,2'b11,0,0,32'h0000_0108,3'b011,0,32'h0,        1,1,0,32'h0,        0,0,1,32'h0000_0108,0,32'h0,0,2'd1);
    // slave wait state in DATA
    add(0,1,2'b11,0,0,32'h0000_010C,3'b011,0,32'h0,        0,0,0,32'h0,        0,0,0,32'h0,0,32'h0,0,2'd2);
    add(0,1,2'b11,1,0,32'h0000_010C,3'b011,0,32'h0,        0,1,0,32'h3333_3333,1,0,0,32'h0,0,32'h3333_3333,0,2'd2);
    add(0,1,2'b11,0,0,32'h0000_010C,3'b011,0,32'h0,        1,1,0,32'h0,        0,0,1,32'h0000_010C,0,32'h0,0,2'd1);
    add(0,0,2'b00,1,0,32'h0,        3'b000,0,32'h0,        0,1,0,32'h4444_4444,1,0,0,32'h0,0,32'h4444_4444,0,2'd2);
    // ERROR on a granted write; grant needs HREADYMUXM too
    add(0,1,2'b10,1,1,32'h0000_0300,3'b000,0,32'h0,        0,1,0,32'h0,        1,0,0,32'h0,0,32'h0,0,2'd0);
    add(0,1,2'b10,0,1,32'h0000_0300,3'b000,0,32'h7,        1,0,0,32'h0,        0,0,1,32'h0000_0300,1,32'h0,0,2'd1);
    add(0,1,2'b10,0,1,32'h0000_0300,3'b000,0,32'h7,        1,1,0,32'h0,        0,0,1,32'h0000_0300,1,32'h0,0,2'd1);
    add(0,0,2'b00,0,0,32'h0,        3'b000,0,32'h7,        0,0,1,32'h0,        0,1,0,32'h0,0,32'h0,0,2'd2);
    add(0,0,2'b00,1,0,32'h0,        3'b000,0,32'h7,        0,1,1,32'h0,        1,1,0,32'h0,0,32'h0,0,2'd2);
    add(0,0,2'b00,1,0,32'h0,        3'b000,0,32'h0,        0,1,1,32'h0,        1,0,0,32'h0,0,32'h0,0,2'd0);
    // Locked pair with an unselected cycle between beats
    add(0,1,2'b10,1,0,32'h0000_0400,3'b000,1,32'h0,        0,1,0,32'h0,        1,0,0,32'h0,0,32'h0,0,2'd0);
    add(0,1,2'b10,0,0,32'h0000_0400,3'b000,1,32'h0,        1,1,0,32'h0,        0,0,1,32'h0000_0400,0,32'h0,1,2'd1);
    add(0,0,2'b00,1,0,32'h0,        3'b000,1,32'h0,        0,1,0,32'h0,        1,0,0,32'h0,0,32'h0,1,2'd2);
    add(0,1,2'b10,1,0,32'h0000_0404,3'b000,1,32'h0,        0,1,0,32'h0,        1,0,0,32'h0,0,32'h0,1,2'd0);
    add(0,1,2'b10,0,0,32'h0000_0404,3'b000,1,32'h0,        1,1,0,32'h0,        0,0,1,32'h0000_0404,0,32'h0,1,2'd1);
    add(0,0,2'b00,1,0,32'h0,        3'b000,0,32'h0,        0,1,0,32'h0,        1,0,0,32'h0,0,32'h0,1,2'd2);
    add(0,0,2'b00,1,0,32'h0,        3'b000,0,32'h0,        0,1,0,32'h0,        1,0,0,32'h0,0,32'h0,0,2'd0);
    // Reset while in PEND with active_op asserted
    add(0,1,2'b10,1,1,32'h0000_0500,3'b000,1,32'h0,        0,1,0,32'h0,        1,0,0,32'h0,0,32'h0,0,2'd0);
    add(1,1,2'b10,0,1,32'h0000_0500,3'b000,1,32'h0,        1,1,0,32'h0,        0,0,1,32'h0000_0500,1,32'h0,1,2'd1);
    add(0,0,2'b00,1,0,32'h0,        3'b000,0,32'h0,        1,1,0,32'h0,        1,0,0,32'h0,0,32'h0,0,2'd0);

    // Reset sequence: held for 3 cycles, then released
    rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = C_SIZE; hburst = 3'b000; hprot = C_PROT; hmaster = C_MID;
    hlock = 1'b0; hwdata = '0; hready = 1'b0; active = 1'b0;
    hreadymuxm = 1'b1; hrespm = 1'b0; hrdatam = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hreadyouts", -1, 64'(hreadyout), 64'd1);
    chk("rst_hresps",     -1, 64'(hresp), 64'd0);
    chk("rst_held",       -1, 64'(held_tran_op), 64'd0);
    chk("rst_sel",        -1, 64'(sel_op), 64'd0);
    chk("rst_trans",      -1, 64'(trans_op), 64'd0);
    chk("rst_addr",       -1, 64'(addr_op), 64'd0);
    chk("rst_ctrl",       -1, 64'({write_op, size_op, burst_op, prot_op, master_op}), 64'd0);
    chk("rst_mastlock",   -1, 64'(mastlock_op), 64'd0);
    chk("rst_hrdatas",    -1, 64'(hrdata), 64'd0);
    chk("rst_state",      -1, 64'(dbg_state), 64'd0);

    // Table-driven body
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1 drive(vecs[i]);
      @(negedge clk);
      check_row(i, vecs[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
